// File: rtl/modbus_pkg.sv
// -----------------------------------------------------------------------------
// modbus_pkg
// Shared definitions for the Modbus RTU receive path:
//   - CRC16 constants (reflected polynomial 0xA001, init 0xFFFF)
//   - bit positions inside the frame_err status word
//   - receive framer state encoding
//   - single-bit CRC16 update helper
// -----------------------------------------------------------------------------
package modbus_pkg;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL = 16'hA001;

  // frame_err bit positions
  localparam int ERR_CRC   = 0;  // residue over all bytes is non-zero
  localparam int ERR_SHORT = 1;  // fewer than 4 bytes including CRC
  localparam int ERR_LONG  = 2;  // more than MAX_LEN bytes
  localparam int ERR_RX    = 3;  // UART error or CRC engine overrun
  localparam int ERR_GAP   = 4;  // inter-character silence reached t1.5
  localparam int ERR_W     = 5;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,  // waiting for t3.5 of proven line silence
    ST_IDLE = 2'd1,  // between frames
    ST_RECV = 2'd2   // collecting a frame
  } state_t;

  // One LSB-first step of the reflected CRC16 shift register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    crc16_step = (crc >> 1) ^ (fb ? CRC_POLY_REFL : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_byte_serial.sv
// -----------------------------------------------------------------------------
// crc16_byte_serial
// Bit-serial CRC16 (reflected, LSB first). A start pulse latches one byte and
// folds it into the running CRC over the following 8 cycles.
//   clk, rst : clock, synchronous active-high reset
//   init     : reload CRC_INIT (with start: the new byte is applied on top of it)
//   start    : accept data (ignored while busy)
//   data     : byte to fold into the CRC
//   busy     : high for the 8 cycles after an accepted start
//   crc      : running CRC value
// -----------------------------------------------------------------------------
module crc16_byte_serial
  import modbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        busy,
  output logic [15:0] crc
);

  logic [15:0] crc_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_cnt_r;
  logic        busy_r;

  // Byte latch, bit counter and CRC shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r     <= CRC_INIT;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      busy_r    <= 1'b0;
    end else if (start && !busy_r) begin
      crc_r     <= init ? CRC_INIT : crc_r;
      shift_r   <= data;
      bit_cnt_r <= 3'd0;
      busy_r    <= 1'b1;
    end else if (busy_r) begin
      crc_r     <= crc16_step(crc_r, shift_r[0]);
      shift_r   <= {1'b0, shift_r[7:1]};
      bit_cnt_r <= bit_cnt_r + 3'd1;
      busy_r    <= (bit_cnt_r != 3'd7);
    end else if (init) begin
      crc_r <= CRC_INIT;
    end
  end

  assign busy = busy_r;
  assign crc  = crc_r;

endmodule

// File: rtl/modbus_frame_rx.sv
// -----------------------------------------------------------------------------
// modbus_frame_rx
// Modbus RTU receive framer: delimits frames by line silence, checks CRC16 over
// every byte and forwards the payload with the two trailing CRC bytes stripped.
//   clk, rst            : clock, synchronous active-high reset
//   rx_data/valid/err   : byte stream from the UART receiver
//   out_data/valid/sop  : payload bytes, sop on the first byte of a frame
//   frame_done          : one-cycle end-of-frame strobe
//   frame_ok/err/len    : frame status, updated with frame_done and held
// -----------------------------------------------------------------------------
module modbus_frame_rx
  import modbus_pkg::*;
#(
  parameter int GAP15   = 85938,
  parameter int GAP35   = 200521,
  parameter int MAX_LEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_err,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [ERR_W-1:0] frame_err,
  output logic [7:0]       frame_len
);

  localparam int GW = $clog2(GAP35 + 1);
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam logic [GW-1:0] GAP15_C   = GW'(GAP15);
  localparam logic [GW-1:0] GAP35_C   = GW'(GAP35);
  localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_SAT_C = LW'(MAX_LEN + 1);

  state_t            state_r, state_nxt_s;
  logic [GW-1:0]     gap_r, gap_inc_s;
  logic [LW-1:0]     len_r, len_inc_s;
  logic [ERR_W-1:0]  err_r, err_set_s, err_final_s;
  logic              byte_first_s, byte_next_s, frame_end_s, emit_s;
  logic              crc_start_s, crc_busy_s;
  logic [15:0]       crc_s;
  logic [7:0]        dly0_r, dly1_r;
  logic [7:0]        out_data_r;
  logic              out_valid_r, out_sop_r, frame_done_r, frame_ok_r;
  logic [ERR_W-1:0]  frame_err_r;
  logic [7:0]        frame_len_r;

  assign gap_inc_s = (gap_r == GAP35_C) ? gap_r : gap_r + GW'(1);
  assign len_inc_s = (len_r == LEN_SAT_C) ? len_r : len_r + LW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and per-cycle byte/frame strobes; a byte always beats the
  // end-of-frame decision in the same cycle
  always_comb begin
    state_nxt_s  = state_r;
    byte_first_s = 1'b0;
    byte_next_s  = 1'b0;
    frame_end_s  = 1'b0;
    case (state_r)
      ST_SYNC: begin
        if (!rx_valid && (gap_inc_s == GAP35_C)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_IDLE: begin
        if (rx_valid) begin
          state_nxt_s  = ST_RECV;
          byte_first_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          state_nxt_s = ST_RECV;
          byte_next_s = 1'b1;
        end else if (gap_inc_s == GAP35_C) begin
          state_nxt_s = ST_IDLE;
          frame_end_s = 1'b1;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      default: begin
        state_nxt_s = ST_SYNC;
      end
    endcase
  end

  // Line-silence counter: cleared by every received byte, saturates at t3.5
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_r <= '0;
    end else if (rx_valid) begin
      gap_r <= '0;
    end else begin
      gap_r <= gap_inc_s;
    end
  end

  // A byte arriving while the engine is busy is counted but not folded in
  assign crc_start_s = byte_first_s | (byte_next_s & ~crc_busy_s);

  crc16_byte_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .init  (byte_first_s),
    .start (crc_start_s),
    .data  (rx_data),
    .busy  (crc_busy_s),
    .crc   (crc_s)
  );

  // Error flags raised by the current byte
  always_comb begin
    err_set_s = '0;
    if (byte_next_s) begin
      err_set_s[ERR_GAP]  = (gap_r >= GAP15_C);
      err_set_s[ERR_RX]   = rx_err | crc_busy_s;
      err_set_s[ERR_LONG] = (len_inc_s > MAX_LEN_C);
    end else if (byte_first_s) begin
      err_set_s[ERR_RX] = rx_err;
    end else begin
      err_set_s = '0;
    end
  end

  // Sticky error flags, restarted by the first byte of each frame
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= '0;
    end else if (byte_first_s) begin
      err_r <= err_set_s;
    end else if (byte_next_s) begin
      err_r <= err_r | err_set_s;
    end
  end

  // End-of-frame error word: sticky flags plus length and residue checks
  always_comb begin
    err_final_s            = err_r;
    err_final_s[ERR_SHORT] = err_r[ERR_SHORT] | (len_r < LW'(4));
    err_final_s[ERR_CRC]   = err_r[ERR_CRC] | (crc_s != 16'h0000);
  end

  // Total byte count, CRC included, saturating one past MAX_LEN
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r <= '0;
    end else if (byte_first_s) begin
      len_r <= LW'(1);
    end else if (byte_next_s) begin
      len_r <= len_inc_s;
    end
  end

  // Two-byte hold-back: the last two bytes of a frame (its CRC) never leave
  always_ff @(posedge clk) begin
    if (rst) begin
      dly0_r <= 8'h00;
      dly1_r <= 8'h00;
    end else if (byte_first_s) begin
      dly0_r <= rx_data;
      dly1_r <= 8'h00;
    end else if (byte_next_s) begin
      dly0_r <= rx_data;
      dly1_r <= dly0_r;
    end
  end

  assign emit_s = byte_next_s && (len_inc_s >= LW'(3)) && (len_inc_s <= MAX_LEN_C);

  // Registered payload output, one cycle after the releasing byte
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
    end else begin
      out_valid_r <= emit_s;
      out_sop_r   <= emit_s && (len_inc_s == LW'(3));
      if (emit_s) begin
        out_data_r <= dly1_r;
      end
    end
  end

  // End-of-frame strobe and held status
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      frame_err_r  <= '0;
      frame_len_r  <= 8'h00;
    end else begin
      frame_done_r <= frame_end_s;
      if (frame_end_s) begin
        frame_err_r <= err_final_s;
        frame_ok_r  <= (err_final_s == '0);
        frame_len_r <= (len_r >= LW'(2)) ? 8'(len_r - LW'(2)) : 8'h00;
      end
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign out_sop    = out_sop_r;
  assign frame_done = frame_done_r;
  assign frame_ok   = frame_ok_r;
  assign frame_err  = frame_err_r;
  assign frame_len  = frame_len_r;

endmodule

// File: tb/tb_modbus_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_modbus_frame_rx
// Directed self-checking bench for modbus_frame_rx with GAP15=40, GAP35=90,
// MAX_LEN=256 and 20-cycle byte spacing unless a scenario needs otherwise.
// -----------------------------------------------------------------------------
module tb_modbus_frame_rx;

  localparam int GAP15   = 40;
  localparam int GAP35   = 90;
  localparam int MAX_LEN = 256;
  localparam int SPACE   = 20;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err   = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_sop, frame_done, frame_ok;
  logic [4:0] frame_err;
  logic [7:0] frame_len;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rx = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  logic [7:0] q_out[$];
  logic       q_sop[$];
  logic [7:0] frm [0:7];

  modbus_frame_rx #(.GAP15(GAP15), .GAP35(GAP35), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .frame_len  (frame_len)
  );

  // Clock
  always #5 clk = ~clk;

  // Edge counter
  always @(posedge clk) cyc <= cyc + 1;

  // Recorder: captures payload bytes and frame_done events mid-cycle
  always @(negedge clk) begin
    if (out_valid) begin
      q_out.push_back(out_data);
      q_sop.push_back(out_sop);
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Present one byte for one edge, then hold the line quiet so that the next
  // byte is sampled exactly 'spacing' edges later.
  task automatic put_byte(input logic [7:0] b, input logic e, input int spacing);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = e;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    last_rx  = cyc;
    for (int i = 1; i < spacing; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] last_b, input int slow_idx,
                            input int slow_gap, input int err_idx);
    for (int i = 0; i < 8; i++) begin
      put_byte((i == 7) ? last_b : frm[i], (i == err_idx),
               (i == slow_idx) ? slow_gap : SPACE);
    end
  endtask

  task automatic wait_done(input int prev, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != prev) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_q;
    q_out.delete();
    q_sop.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    idle(4);
    rx_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (out_sop !== 1'b0) begin n_fail++; $display("FAIL reset_out_sop got %b exp 0", out_sop); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    n_chk++; if (frame_ok !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ok got %b exp 0", frame_ok); end
    n_chk++; if (frame_err !== 5'b00000) begin n_fail++; $display("FAIL reset_frame_err got %b exp 00000", frame_err); end
    n_chk++; if (frame_len !== 8'h00) begin n_fail++; $display("FAIL reset_frame_len got %0d exp 0", frame_len); end
    rst = 1'b0;
  endtask

  task automatic test_good;
    int prev;
    int sops;
    logic [7:0] got;
    idle(100);
    clear_q();
    prev = done_cnt;
    send_frame(8'hCD, -1, 0, -1);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL good_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (done_cyc - last_rx !== GAP35) begin n_fail++; $display("FAIL good_done_latency got %0d exp %0d", done_cyc - last_rx, GAP35); end
    n_chk++; if (q_out.size() !== 6) begin n_fail++; $display("FAIL good_out_count got %0d exp 6", q_out.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < q_out.size()) ? q_out[i] : 8'hxx;
      n_chk++; if (got !== frm[i]) begin n_fail++; $display("FAIL good_payload[%0d] got %h exp %h", i, got, frm[i]); end
    end
    sops = 0;
    foreach (q_sop[i]) if (q_sop[i]) sops++;
    n_chk++; if (q_sop.size() == 0 || q_sop[0] !== 1'b1 || sops !== 1) begin n_fail++; $display("FAIL good_sop got %0d sop flags exp 1 on first byte", sops); end
    n_chk++; if (frame_ok !== 1'b1) begin n_fail++; $display("FAIL good_frame_ok got %b exp 1", frame_ok); end
    n_chk++; if (frame_err !== 5'b00000) begin n_fail++; $display("FAIL good_frame_err got %b exp 00000", frame_err); end
    n_chk++; if (frame_len !== 8'd6) begin n_fail++; $display("FAIL good_frame_len got %0d exp 6", frame_len); end
  endtask

  task automatic test_crc_bad;
    int prev;
    logic [7:0] got;
    idle(10);
    clear_q();
    prev = done_cnt;
    send_frame(8'hCE, -1, 0, -1);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL crc_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (q_out.size() !== 6) begin n_fail++; $display("FAIL crc_out_count got %0d exp 6", q_out.size()); end
    got = (q_out.size() > 5) ? q_out[5] : 8'hxx;
    n_chk++; if (got !== 8'h0A) begin n_fail++; $display("FAIL crc_last_payload got %h exp 0a", got); end
    n_chk++; if (frame_err !== 5'b00001) begin n_fail++; $display("FAIL crc_frame_err got %b exp 00001", frame_err); end
    n_chk++; if (frame_ok !== 1'b0) begin n_fail++; $display("FAIL crc_frame_ok got %b exp 0", frame_ok); end
  endtask

  task automatic test_short;
    int prev;
    idle(10);
    clear_q();
    prev = done_cnt;
    put_byte(8'h01, 1'b0, SPACE);
    put_byte(8'h03, 1'b0, SPACE);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL short_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (q_out.size() !== 0) begin n_fail++; $display("FAIL short_out_count got %0d exp 0", q_out.size()); end
    n_chk++; if (frame_err !== 5'b00011) begin n_fail++; $display("FAIL short_frame_err got %b exp 00011", frame_err); end
    n_chk++; if (frame_len !== 8'd0) begin n_fail++; $display("FAIL short_frame_len got %0d exp 0", frame_len); end
  endtask

  task automatic test_slow_gap;
    int prev;
    idle(10);
    clear_q();
    prev = done_cnt;
    send_frame(8'hCD, 2, 60, -1);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL gap60_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (q_out.size() !== 6) begin n_fail++; $display("FAIL gap60_out_count got %0d exp 6", q_out.size()); end
    n_chk++; if (frame_err !== 5'b10000) begin n_fail++; $display("FAIL gap60_frame_err got %b exp 10000", frame_err); end
    n_chk++; if (frame_len !== 8'd6) begin n_fail++; $display("FAIL gap60_frame_len got %0d exp 6", frame_len); end
  endtask

  task automatic test_gap_boundary;
    int prev;
    idle(10);
    clear_q();
    prev = done_cnt;
    send_frame(8'hCD, 1, GAP35, -1);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL gap35_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (frame_err !== 5'b10000) begin n_fail++; $display("FAIL gap35_frame_err got %b exp 10000", frame_err); end
    n_chk++; if (frame_len !== 8'd6) begin n_fail++; $display("FAIL gap35_frame_len got %0d exp 6", frame_len); end
  endtask

  task automatic test_rx_err;
    int prev;
    idle(10);
    prev = done_cnt;
    send_frame(8'hCD, -1, 0, 3);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL rxerr_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (frame_err !== 5'b01000) begin n_fail++; $display("FAIL rxerr_frame_err got %b exp 01000", frame_err); end
  endtask

  task automatic test_overrun;
    int prev;
    idle(10);
    prev = done_cnt;
    send_frame(8'hCD, 0, 4, -1);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL overrun_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (frame_err[3] !== 1'b1) begin n_fail++; $display("FAIL overrun_err3 got %b exp 1", frame_err[3]); end
    n_chk++; if (frame_len !== 8'd6) begin n_fail++; $display("FAIL overrun_frame_len got %0d exp 6", frame_len); end
  endtask

  task automatic test_long;
    int prev;
    logic [7:0] got;
    idle(10);
    clear_q();
    prev = done_cnt;
    for (int i = 0; i < 260; i++) put_byte(8'(i), 1'b0, SPACE);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL long_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (q_out.size() !== 254) begin n_fail++; $display("FAIL long_out_count got %0d exp 254", q_out.size()); end
    got = (q_out.size() > 253) ? q_out[253] : 8'hxx;
    n_chk++; if (got !== 8'hFD) begin n_fail++; $display("FAIL long_last_payload got %h exp fd", got); end
    n_chk++; if (frame_err[4:1] !== 4'b0010) begin n_fail++; $display("FAIL long_frame_err got %b exp 0010x", frame_err); end
    n_chk++; if (frame_len !== 8'd255) begin n_fail++; $display("FAIL long_frame_len got %0d exp 255", frame_len); end
  endtask

  task automatic test_reset_sync;
    int prev;
    idle(10);
    prev = done_cnt;
    for (int i = 0; i < 3; i++) put_byte(frm[i], 1'b0, SPACE);
    rst = 1'b1;
    idle(3);
    clear_q();
    rst = 1'b0;
    idle(29);
    put_byte(8'h01, 1'b0, 100);
    n_chk++; if (done_cnt !== prev) begin n_fail++; $display("FAIL sync_no_done got %0d exp %0d", done_cnt, prev); end
    n_chk++; if (q_out.size() !== 0) begin n_fail++; $display("FAIL sync_no_output got %0d exp 0", q_out.size()); end
    send_frame(8'hCD, -1, 0, -1);
    wait_done(prev, 200);
    n_chk++; if (done_cnt !== prev + 1) begin n_fail++; $display("FAIL sync_done_count got %0d exp %0d", done_cnt, prev + 1); end
    n_chk++; if (frame_ok !== 1'b1) begin n_fail++; $display("FAIL sync_frame_ok got %b exp 1", frame_ok); end
    n_chk++; if (q_out.size() !== 6) begin n_fail++; $display("FAIL sync_out_count got %0d exp 6", q_out.size()); end
  endtask

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "simulation timeout");
  end

  // Test sequence
  initial begin
    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
    @(posedge clk); #1;
    test_reset();
    test_good();
    test_crc_bad();
    test_short();
    test_slow_gap();
    test_gap_boundary();
    test_rx_err();
    test_overrun();
    test_long();
    test_reset_sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
